// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART receive path: state encoding, frame width
// and the sample-tick divider computation.
package uart_rx_fsm_pkg;

    // Data bits per frame (8N1). The transmit side uses the same width.
    localparam int DATA_BITS = 8;

    // Receiver FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Clocks per sample tick, integer-truncated. Clamped to 1 so that a
    // too-fast line rate still yields a usable tick every clock.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick generator: one-clock pulse every DIV clocks.
module uart_os_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter, wraps at DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: synchronises rx, qualifies the start bit at mid-bit,
// samples data LSB-first at mid-bit and checks the stop bit.
//
// Output handshake: rx_valid is a one-clock strobe with no ready/back-pressure;
// rx_data holds the last good byte until the next good frame overwrites it,
// so the consumer must capture it within one frame time. frame_err is a
// one-clock strobe that never coincides with rx_valid.
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output rx_state_t  state
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    BC_LAST = 4'(DATA_BITS - 1);

    logic                 tick;
    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            next_state;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 at_half;
    logic                 at_full;
    logic                 valid_set;
    logic                 ferr_set;

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_s) next_state = START;
            START:   if (at_half) next_state = rx_s ? IDLE : DATA;
            DATA:    if (at_full && bit_cnt == BC_LAST) next_state = STOP;
            STOP:    if (at_full) next_state = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Sample-point decodes, strobe requests and busy flag.
    always_comb begin
        at_half   = tick && (tick_cnt == TC_HALF);
        at_full   = tick && (tick_cnt == TC_FULL);
        valid_set = (state == STOP) && at_full && rx_s;
        ferr_set  = (state == STOP) && at_full && !rx_s;
        busy      = (state != IDLE);
    end

    // Tick/bit counters and data shift register (LSB arrives first).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
                START: begin
                    if (at_half)   tick_cnt <= '0;
                    else if (tick) tick_cnt <= tick_cnt + TW'(1);
                end
                DATA: begin
                    if (at_full) begin
                        tick_cnt <= '0;
                        bit_cnt  <= bit_cnt + 4'd1;
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                STOP: begin
                    if (at_full)   tick_cnt <= '0;
                    else if (tick) tick_cnt <= tick_cnt + TW'(1);
                end
                default: tick_cnt <= '0;
            endcase
        end
    end

    // Registered outputs: byte capture and one-clock strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= valid_set;
            frame_err <= ferr_set;
            if (valid_set) rx_data <= shreg;
        end
    end

endmodule
